// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Address width for a given register count; never narrower than one bit.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int port_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write, read and clear-control bundle of the register file.
interface regfile_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
);
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic                 clr_req;
  logic                 busy;
  logic                 clr_done;

  modport master (
    output we, wa, wd, ra, clr_req,
    input  rd, busy, clr_done
  );

  modport slave (
    input  we, wa, wd, ra, clr_req,
    output rd, busy, clr_done
  );
endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps zeros through every register after reset or on request.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_t     state_p0, state_d;
  logic [AW-1:0] ptr_p0, ptr_d;
  logic          done_p0, done_d;

  // Stage p0: sequencer state, sweep pointer and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= RF_CLEAR;
      ptr_p0   <= '0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_d;
      ptr_p0   <= ptr_d;
      done_p0  <= done_d;
    end
  end

  always_comb begin
    state_d = state_p0;
    ptr_d   = ptr_p0;
    done_d  = 1'b0;
    busy    = 1'b0;
    clr_we  = 1'b0;
    case (state_p0)
      RF_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        ptr_d  = ptr_p0 + AW'(1);
        if (ptr_p0 == LAST) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end
      end
      RF_IDLE: begin
        // A request while already sweeping never reaches here, so it is ignored.
        if (clr_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_addr = ptr_p0;
  assign clr_done = done_p0;

endmodule

// File: rtl/regfile_multi.sv
// Parametrised register file: NRD combinational read ports, one write port,
// optional write-to-read bypass and a hardware clear sweep.
module regfile_multi
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave bus
);

  localparam int AW = calc_aw(NREGS);

  logic                 busy;
  logic                 clr_done;
  logic                 clr_we;
  logic [AW-1:0]        clr_addr;
  logic                 wa_zero;
  logic                 user_we;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [WIDTH-1:0]     mem_data;
  logic [NRD*WIDTH-1:0] rd_all;
  logic [WIDTH-1:0]     rf [NREGS];

  regfile_clr_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (bus.clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy),
    .clr_done (clr_done)
  );

  assign bus.busy     = busy;
  assign bus.clr_done = clr_done;

  // A clear request in the same cycle as a write takes priority and drops the write.
  assign wa_zero  = (ZERO_REG != 0) && (bus.wa == '0);
  assign user_we  = !busy && bus.we && !bus.clr_req && !wa_zero;
  assign mem_we   = clr_we || user_we;
  assign mem_addr = clr_we ? clr_addr : bus.wa;
  assign mem_data = clr_we ? '0 : bus.wd;

  // Stage p0: storage array, cleared only by the sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      rf[mem_addr] <= mem_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    assign addr = bus.ra[port_lsb(g, AW) +: AW];

    always_comb begin
      data = rf[addr];
      if (busy) begin
        data = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end else if ((BYPASS != 0) && user_we && (addr == bus.wa)) begin
        data = bus.wd;
      end
    end

    assign rd_all[port_lsb(g, WIDTH) +: WIDTH] = data;
  end

  assign bus.rd = rd_all;

endmodule
